// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational adder_sub among NUM_REQ requesters.
// One operation in flight at a time: IDLE grants, EXEC lets the datapath settle, RESP holds the result.
module addsub_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]       req_op,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic                     alu_add_sub,
   input  logic [WIDTH-1:0]         alu_o,
   input  logic                     alu_c,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_o,
   output logic                     rsp_c,
   input  logic                     rsp_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state;
   state_t              state_next;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     ptr_next;
   logic [ID_W-1:0]     grant_id;
   logic [NUM_REQ-1:0]  grant;
   logic                grant_found;
   logic                accept;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;
   logic                sel_op;

   // Search upward from rr_ptr, wrapping, for the first asserted request.
   always_comb begin : rr_search
      int idx;
      grant       = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
            grant[idx[ID_W-1:0]] = 1'b1;
            grant_id             = idx[ID_W-1:0];
            grant_found          = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a  = req_a[i*WIDTH +: WIDTH];
            sel_b  = req_b[i*WIDTH +: WIDTH];
            sel_op = req_op[i];
         end
      end
   end

   assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign accept    = (state == IDLE) && grant_found;
   // Gated by rst_n so no grant is visible while the block is held in reset.
   assign req_ready = (state == IDLE && rst_n) ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_add_sub <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_o       <= '0;
         rsp_c       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_a       <= sel_a;
                  alu_b       <= sel_b;
                  alu_add_sub <= sel_op;
                  rsp_id      <= grant_id;
                  rr_ptr      <= ptr_next;
               end
            end
            EXEC: begin
               rsp_o     <= alu_o;
               rsp_c     <= alu_c;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: transaction-level model plus directed and random stimulus.
module tb_addsub_arbiter;

   localparam int N  = 4;
   localparam int W  = 2;
   localparam int IW = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N*W-1:0]    req_a;
   logic [N*W-1:0]    req_b;
   logic [N-1:0]      req_op;
   logic [N-1:0]      req_ready;
   logic [W-1:0]      alu_a;
   logic [W-1:0]      alu_b;
   logic              alu_add_sub;
   logic [W-1:0]      alu_o;
   logic              alu_c;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_o;
   logic              rsp_c;
   logic              rsp_ready;
   logic              busy;
   logic [W:0]        alu_sum;

   int vectors    = 0;
   int miscompares = 0;

   addsub_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .req_ready(req_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_add_sub(alu_add_sub),
      .alu_o(alu_o), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_o(rsp_o), .rsp_c(rsp_c),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   // Stand-in for the shared adder_sub datapath.
   assign alu_sum = alu_add_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1)
                                : ({1'b0, alu_a} + {1'b0, alu_b});
   assign alu_o = alu_sum[W-1:0];
   assign alu_c = alu_sum[W];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
   endtask

   function automatic int rrChoice(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oneHot(input int c);
      logic [N-1:0] r;
      r = '0;
      if (c >= 0) r[c] = 1'b1;
      return r;
   endfunction

   // Result as {carry, out}: plain modular arithmetic, subtract carry means a >= b.
   function automatic logic [W:0] resultOf(input int a, input int b, input logic op);
      int o;
      logic c;
      logic [W:0] r;
      if (op) begin
         o = (a - b + (1 << W)) % (1 << W);
         c = (a >= b);
      end else begin
         o = (a + b) % (1 << W);
         c = ((a + b) >= (1 << W));
      end
      r[W-1:0] = o[W-1:0];
      r[W]     = c;
      return r;
   endfunction

   // Transaction-level reference: one op in flight, response visible two edges after accept.
   int           model_choice;
   logic         m_inflight;
   int           m_age;
   int           m_ptr;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   logic         m_op;
   int           m_id;
   logic [W:0]   m_res;
   logic [N-1:0] acc_mask;

   always_comb model_choice = rrChoice(req_valid, m_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_inflight <= 1'b0;
         m_age      <= 0;
         m_ptr      <= 0;
         m_a        <= '0;
         m_b        <= '0;
         m_op       <= 1'b0;
         m_id       <= 0;
         m_res      <= '0;
         acc_mask   <= '0;
      end else begin
         acc_mask <= '0;
         if (!m_inflight) begin
            if (model_choice >= 0) begin
               m_inflight <= 1'b1;
               m_age      <= 1;
               m_ptr      <= (model_choice + 1) % N;
               m_id       <= model_choice;
               m_a        <= req_a[model_choice*W +: W];
               m_b        <= req_b[model_choice*W +: W];
               m_op       <= req_op[model_choice];
               m_res      <= resultOf(int'(req_a[model_choice*W +: W]),
                                      int'(req_b[model_choice*W +: W]), req_op[model_choice]);
               acc_mask   <= oneHot(model_choice);
            end
         end else if (m_age == 1) begin
            m_age <= 2;
         end else if (rsp_ready) begin
            m_inflight <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_req_ready", req_ready, 0);
         checkOutput("rst_rsp_valid", rsp_valid, 0);
         checkOutput("rst_busy", busy, 0);
      end else begin
         checkOutput("busy", busy, m_inflight);
         checkOutput("req_ready", req_ready, m_inflight ? '0 : oneHot(model_choice));
         checkOutput("alu_a", alu_a, m_a);
         checkOutput("alu_b", alu_b, m_b);
         checkOutput("alu_add_sub", alu_add_sub, m_op);
         checkOutput("rsp_valid", rsp_valid, (m_inflight && m_age >= 2));
         if (m_inflight && m_age >= 2) begin
            checkOutput("rsp_id", rsp_id, m_id);
            checkOutput("rsp_o", rsp_o, m_res[W-1:0]);
            checkOutput("rsp_c", rsp_c, m_res[W]);
         end
      end
   end

   task automatic applyStimulus(input int id, input int a, input int b, input logic op);
      req_valid[id]      = 1'b1;
      req_a[id*W +: W]   = W'(a);
      req_b[id*W +: W]   = W'(b);
      req_op[id]         = op;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_req_ready"}, req_ready, 0);
      checkOutput({tag, "_alu_a"}, alu_a, 0);
      checkOutput({tag, "_alu_b"}, alu_b, 0);
      checkOutput({tag, "_alu_add_sub"}, alu_add_sub, 0);
      checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, "_rsp_id"}, rsp_id, 0);
      checkOutput({tag, "_rsp_o"}, rsp_o, 0);
      checkOutput({tag, "_rsp_c"}, rsp_c, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from an idle block with rsp_ready high; returns with the response visible.
   task automatic runOp(input int id, input int a, input int b, input logic op);
      applyStimulus(id, a, b, op);
      step();
      req_valid[id] = 1'b0;
      step();
   endtask

   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      repeat (2) step();
      checkAllZero("reset");
      rst_n = 1'b1;

      $display("[TB] single add on requester 1");
      step();
      applyStimulus(1, 2, 1, 1'b0);
      #2;
      checkOutput("a_grant", req_ready, 4'b0010);
      step();
      req_valid[1] = 1'b0;
      checkOutput("a_alu_a", alu_a, 2);
      checkOutput("a_alu_b", alu_b, 1);
      checkOutput("a_exec_ready", req_ready, 0);
      checkOutput("a_exec_valid", rsp_valid, 0);
      step();
      checkOutput("a_rsp_valid", rsp_valid, 1);
      checkOutput("a_rsp_id", rsp_id, 1);
      checkOutput("a_rsp_o", rsp_o, 3);
      checkOutput("a_rsp_c", rsp_c, 0);
      rsp_ready = 1'b1;
      step();
      checkOutput("a_done_valid", rsp_valid, 0);
      checkOutput("a_done_busy", busy, 0);

      $display("[TB] subtracts on requester 0");
      runOp(0, 1, 2, 1'b1);
      checkOutput("sub1_o", rsp_o, 3);
      checkOutput("sub1_c", rsp_c, 0);
      step();
      runOp(0, 3, 1, 1'b1);
      checkOutput("sub2_o", rsp_o, 2);
      checkOutput("sub2_c", rsp_c, 1);
      step();

      $display("[TB] all requesters valid, round-robin order");
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) applyStimulus(i, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      #1;
      for (int n = 0; n < 5; n++) begin
         checkOutput($sformatf("rr_grant%0d", n), req_ready, oneHot(order[n]));
         checkOutput($sformatf("rr_onehot%0d", n), $countones(req_ready), 1);
         step();
         if (n == 4) req_valid = '0;
         else applyStimulus(order[n], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         repeat (2) step();
      end

      $display("[TB] response held while rsp_ready low");
      rsp_ready = 1'b0;
      applyStimulus(3, 3, 3, 1'b0);
      step();
      req_valid[3] = 1'b0;
      applyStimulus(1, 0, 1, 1'b1);
      checkOutput("hold_exec_busy", busy, 1);
      step();
      for (int n = 0; n < 5; n++) begin
         checkOutput("hold_valid", rsp_valid, 1);
         checkOutput("hold_id", rsp_id, 3);
         checkOutput("hold_o", rsp_o, 2);
         checkOutput("hold_c", rsp_c, 1);
         checkOutput("hold_busy", busy, 1);
         checkOutput("hold_ready", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      checkOutput("hold_last_valid", rsp_valid, 1);
      step();
      checkOutput("hold_release_valid", rsp_valid, 0);
      checkOutput("hold_release_busy", busy, 0);
      checkOutput("wrap_grant", req_ready, 4'b0010);
      step();
      req_valid[1] = 1'b0;
      step();
      checkOutput("wrap_rsp_id", rsp_id, 1);
      checkOutput("wrap_rsp_o", rsp_o, 3);
      checkOutput("wrap_rsp_c", rsp_c, 0);
      step();

      $display("[TB] reset during EXEC");
      applyStimulus(2, 3, 2, 1'b0);
      step();
      checkOutput("mid_alu_a", alu_a, 3);
      checkOutput("mid_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      applyStimulus(3, 1, 1, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput("post_reset_grant", req_ready, 4'b0100);
      checkOutput("post_reset_busy", busy, 0);

      $display("[TB] random traffic");
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               applyStimulus(i, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
